// File: rtl/lifo_arb_pkg.sv
// Shared types and op encodings for the lifo arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lifo_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/lifo_arbiter_if.sv
// Client-side command/response bundle for the lifo arbiter.
// Latency: n/a; response arrives one cycle after the accepting cycle.
// Backpressure: req_ready_o is the one-hot accept; clients hold a command until accepted.
// Ports: req_valid_i/req_op_i/req_data_i (client -> arbiter),
//        req_ready_o/rsp_valid_o/rsp_err_o/rsp_data_o (arbiter -> client).
interface lifo_arbiter_if #(
  parameter int N_CLIENTS = 4,
  parameter int DWIDTH    = 16
);

  logic [N_CLIENTS-1:0]        req_valid_i;
  logic [N_CLIENTS-1:0]        req_op_i;
  logic [N_CLIENTS*DWIDTH-1:0] req_data_i;
  logic [N_CLIENTS-1:0]        req_ready_o;
  logic [N_CLIENTS-1:0]        rsp_valid_o;
  logic                        rsp_err_o;
  logic [DWIDTH-1:0]           rsp_data_o;

  // Requesting clients.
  modport master (
    output req_valid_i, req_op_i, req_data_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o
  );

  // The arbiter.
  modport slave (
    input  req_valid_i, req_op_i, req_data_i,
    output req_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// Latency: grant is combinational; the priority pointer moves on the clock after advance.
// Backpressure: the pointer only moves when advance is high, so an unaccepted grant keeps its priority.
// Ports: clk, rst_n (async, active low), req[N], advance; grant[N] one-hot.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;
  int            idx;

  // Search starts just past the last winner and wraps, so the last winner is
  // always checked last.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        ptr_d              = idx[PW-1:0];
        found              = 1'b1;
      end
    end
  end

  // Reset to the highest index so client 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PW'(N - 1);
    end else if (advance && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one lifo between N_CLIENTS push/pop requesters, round-robin, one op per cycle, with a drain sequencer.
// Latency: lifo strobe in the accept cycle; per-client response (valid/err/data) exactly one cycle later.
// Backpressure: one-hot req_ready_o in RUN only; no accepts while draining. Rejected ops are consumed with err.
// Ports: clk_i, arstn_i; bus (client command/response, slave side); flush_i, flush_done_o, busy_o;
//        lifo_wrreq_o/lifo_rdreq_o/lifo_data_o to the lifo; lifo_q_i/empty/full/usedw from the lifo.
module lifo_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 8
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  lifo_arbiter_if.slave     bus,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic              busy_o,
  output logic              lifo_wrreq_o,
  output logic              lifo_rdreq_o,
  output logic [DWIDTH-1:0] lifo_data_o,
  input  logic [DWIDTH-1:0] lifo_q_i,
  input  logic              lifo_empty_i,
  input  logic              lifo_full_i,
  input  logic [AWIDTH:0]   lifo_usedw_i
);

  localparam logic [AWIDTH:0] USEDW_MAX = {1'b1, {AWIDTH{1'b0}}};

  state_t                state_q;
  state_t                state_d;
  logic [N_CLIENTS-1:0]  arb_req;
  logic [N_CLIENTS-1:0]  grant;
  logic [N_CLIENTS-1:0]  hs;
  logic                  any_hs;
  logic                  sel_op;
  logic [DWIDTH-1:0]     sel_data;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  rejected;
  logic                  drain_rd;
  logic [N_CLIENTS-1:0]  rsp_vld_q;
  logic                  rsp_err_q;
  logic                  rsp_pop_q;

  // Arbitration is only open in RUN.
  assign arb_req = (state_q == RUN) ? bus.req_valid_i : '0;

  rr_arbiter #(.N(N_CLIENTS)) u_rr (
    .clk     (clk_i),
    .rst_n   (arstn_i),
    .req     (arb_req),
    .advance (any_hs),
    .grant   (grant)
  );

  // Ready is combinational from valid, so it is gated by reset to keep all
  // outputs low while arstn_i is asserted.
  assign bus.req_ready_o = arstn_i ? grant : '0;
  assign hs              = bus.req_valid_i & bus.req_ready_o;
  assign any_hs          = |hs;

  always_comb begin
    sel_op   = OP_PUSH;
    sel_data = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant[i]) begin
        sel_op   = bus.req_op_i[i];
        sel_data = bus.req_data_i[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Flags reflect every op up to last cycle; with one op per cycle they are exact.
  assign push_ok  = any_hs && (sel_op == OP_PUSH) && !lifo_full_i;
  assign pop_ok   = any_hs && (sel_op == OP_POP) && !lifo_empty_i;
  assign rejected = any_hs && !push_ok && !pop_ok;
  assign drain_rd = (state_q == FLUSH) && !lifo_empty_i;

  // Handshakes only happen in RUN and draining only in FLUSH, so the two
  // read sources never overlap and a write never coincides with a read.
  assign lifo_wrreq_o = push_ok;
  assign lifo_rdreq_o = pop_ok || drain_rd;
  assign lifo_data_o  = push_ok ? sel_data : '0;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_o       = 1'b0;
    flush_done_o = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_i) state_d = FLUSH;
      end
      FLUSH: begin
        busy_o = 1'b1;
        if (lifo_empty_i) state_d = DONE;
      end
      DONE: begin
        flush_done_o = 1'b1;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Response pipeline: one stage, matching the lifo read latency so q lines
  // up with the response strobe.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rsp_vld_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_pop_q <= 1'b0;
    end else begin
      rsp_vld_q <= hs;
      rsp_err_q <= rejected;
      rsp_pop_q <= pop_ok;
    end
  end

  assign bus.rsp_valid_o = rsp_vld_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_data_o  = rsp_pop_q ? lifo_q_i : '0;

  a_excl: assert property (@(posedge clk_i) disable iff (!arstn_i)
    !(lifo_wrreq_o && lifo_rdreq_o));

  a_usedw: assert property (@(posedge clk_i) disable iff (!arstn_i)
    lifo_usedw_i <= USEDW_MAX);

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_hold
    a_valid_hold: assert property (@(posedge clk_i) disable iff (!arstn_i)
      (bus.req_valid_i[i] && !bus.req_ready_o[i]) |=> bus.req_valid_i[i]);
    a_op_hold: assert property (@(posedge clk_i) disable iff (!arstn_i)
      (bus.req_valid_i[i] && !bus.req_ready_o[i]) |=> $stable(bus.req_op_i[i]));
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Self-checking bench for lifo_arbiter: behavioural lifo, queue-based reference model, directed + random steps.
// Latency: checks outputs every cycle at the falling edge against the model's prediction.
// Backpressure: bench clients hold valid/op/data until the predicted grant accepts them.
module tb_lifo_arbiter;
  import lifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int M_RUN = 0, M_FLUSH = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  lifo_arbiter_if #(.N_CLIENTS(N), .DWIDTH(DW)) bus ();

  logic          flush;
  logic          flush_done, busy, wr, rd;
  logic [DW-1:0] ldata, lq;
  logic          lempty, lfull;
  logic [AW:0]   lusedw;

  lifo_arbiter #(.N_CLIENTS(N), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i        (clk),
    .arstn_i      (arstn),
    .bus          (bus),
    .flush_i      (flush),
    .flush_done_o (flush_done),
    .busy_o       (busy),
    .lifo_wrreq_o (wr),
    .lifo_rdreq_o (rd),
    .lifo_data_o  (ldata),
    .lifo_q_i     (lq),
    .lifo_empty_i (lempty),
    .lifo_full_i  (lfull),
    .lifo_usedw_i (lusedw)
  );

  // Behavioural lifo with one-cycle read latency.
  int            lcnt;
  logic [DW-1:0] lmem [DEPTH];
  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      lcnt <= 0;
      lq   <= '0;
    end else if (wr && lcnt < DEPTH) begin
      lmem[lcnt] <= ldata;
      lcnt       <= lcnt + 1;
    end else if (rd && lcnt > 0) begin
      lq   <= lmem[lcnt-1];
      lcnt <= lcnt - 1;
    end
  end
  assign lempty = (lcnt == 0);
  assign lfull  = (lcnt == DEPTH);
  assign lusedw = lcnt[AW:0];

  // Reference model state.
  int            vectors = 0;
  int            miscompares = 0;
  int            m_ptr, m_state;
  logic [DW-1:0] stk[$];
  logic [N-1:0]  m_rsp_mask;
  logic          m_rsp_err;
  logic [DW-1:0] m_rsp_data;
  int            grants[$];
  int            obs_flush_rd, obs_done, refill_pct;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_ready"},      bus.req_ready_o, 0);
    chk({t, "_rsp_valid"},  bus.rsp_valid_o, 0);
    chk({t, "_rsp_err"},    bus.rsp_err_o, 0);
    chk({t, "_rsp_data"},   bus.rsp_data_o, 0);
    chk({t, "_flush_done"}, flush_done, 0);
    chk({t, "_busy"},       busy, 0);
    chk({t, "_wrreq"},      wr, 0);
    chk({t, "_rdreq"},      rd, 0);
    chk({t, "_ldata"},      ldata, 0);
  endtask

  task automatic model_reset();
    m_ptr      = N - 1;
    m_state    = M_RUN;
    stk.delete();
    m_rsp_mask = '0;
    m_rsp_err  = 1'b0;
    m_rsp_data = '0;
  endtask

  task automatic req(input int c, input logic op, input logic [DW-1:0] d);
    bus.req_valid_i[c]         = 1'b1;
    bus.req_op_i[c]            = op;
    bus.req_data_i[c*DW +: DW] = d;
  endtask

  // One clock: compare all outputs with the model, advance the model, update clients.
  task automatic cycle();
    int            g;
    logic          ew, er, op_g;
    logic [DW-1:0] d_g;
    @(negedge clk);
    g = -1;
    if (m_state == M_RUN)
      for (int k = 1; k <= N; k++)
        if (g < 0 && bus.req_valid_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    op_g = 1'b0;
    d_g  = '0;
    if (g >= 0) begin
      op_g = bus.req_op_i[g];
      d_g  = bus.req_data_i[g*DW +: DW];
    end
    ew = (g >= 0) && !op_g && (stk.size() < DEPTH);
    er = ((g >= 0) && op_g && (stk.size() > 0)) || (m_state == M_FLUSH && stk.size() > 0);
    chk("req_ready", bus.req_ready_o, (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("lifo_wrreq", wr, ew);
    chk("lifo_rdreq", rd, er);
    chk("wr_rd_excl", wr & rd, 0);
    chk("lifo_data", ldata, ew ? d_g : '0);
    chk("rsp_valid", bus.rsp_valid_o, m_rsp_mask);
    chk("rsp_err", bus.rsp_err_o, m_rsp_err);
    chk("rsp_data", bus.rsp_data_o, m_rsp_data);
    chk("busy", busy, m_state == M_FLUSH);
    chk("flush_done", flush_done, m_state == M_DONE);
    chk("usedw", lusedw, stk.size());
    if (busy && rd) obs_flush_rd++;
    if (flush_done) obs_done++;
    m_rsp_mask = '0;
    m_rsp_err  = 1'b0;
    m_rsp_data = '0;
    if (g >= 0) begin
      m_ptr = g;
      grants.push_back(g);
      m_rsp_mask[g] = 1'b1;
      if (!op_g) begin
        if (ew) stk.push_back(d_g);
        else m_rsp_err = 1'b1;
      end else if (stk.size() > 0) begin
        m_rsp_data = stk.pop_back();
      end else begin
        m_rsp_err = 1'b1;
      end
    end
    case (m_state)
      M_RUN:   if (flush) m_state = M_FLUSH;
      M_FLUSH: if (stk.size() > 0) void'(stk.pop_back()); else m_state = M_DONE;
      default: m_state = M_RUN;
    endcase
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (g >= 0) bus.req_valid_i[g] = 1'b0;
    for (int c = 0; c < N; c++)
      if (!bus.req_valid_i[c] && $urandom_range(0, 99) < refill_pct)
        req(c, 1'($urandom_range(0, 1)), DW'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i = '0;
    bus.req_op_i    = '0;
    bus.req_data_i  = '0;
    flush           = 1'b0;
    refill_pct      = 0;
    obs_flush_rd    = 0;
    obs_done        = 0;
    model_reset();

    // Reset: outputs low even with requests pending.
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid_i = '1;
    #1;
    chk_zero("rst0");
    bus.req_valid_i = '0;
    arstn = 1'b1;

    // Two pushes from client 0, two pops from client 2: LIFO order.
    req(0, OP_PUSH, 16'h1111); cycle();
    req(0, OP_PUSH, 16'h2222); cycle();
    req(2, OP_POP, '0);        cycle();
    chk("t1_pop1_valid", bus.rsp_valid_o, 4'b0100);
    chk("t1_pop1_data", bus.rsp_data_o, 16'h2222);
    chk("t1_pop1_err", bus.rsp_err_o, 0);
    req(2, OP_POP, '0);        cycle();
    chk("t1_pop2_valid", bus.rsp_valid_o, 4'b0100);
    chk("t1_pop2_data", bus.rsp_data_o, 16'h1111);

    // Pop from empty.
    req(1, OP_POP, '0); cycle();
    chk("t3_err", bus.rsp_err_o, 1);
    chk("t3_data", bus.rsp_data_o, 0);
    chk("t3_usedw", lusedw, 0);
    cycle();

    // Fill to capacity, overflow, then drain in reverse order.
    for (int i = 0; i < DEPTH; i++) begin
      req(3, OP_PUSH, DW'(i + 1)); cycle();
    end
    req(3, OP_PUSH, 16'hBEEF); cycle();
    chk("t4_full_err", bus.rsp_err_o, 1);
    chk("t4_usedw", lusedw, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      req(1, OP_POP, '0); cycle();
      chk("t4_pop", bus.rsp_data_o, DW'(DEPTH - i));
    end

    // All clients continuously requesting, random ops: strict rotation.
    grants.delete();
    refill_pct = 100;
    for (int c = 0; c < N; c++) req(c, 1'($urandom_range(0, 1)), DW'($urandom));
    repeat (16) cycle();
    refill_pct = 0;
    chk("t2_count", grants.size(), 16);
    chk("t2_first", grants[0], 2);
    for (int i = 1; i < grants.size(); i++)
      chk("t2_rr", grants[i], (grants[i-1] + 1) % N);
    for (int i = 0; i < 20 && bus.req_valid_i != '0; i++) cycle();
    chk("t2_drain", bus.req_valid_i, 0);

    // Random traffic with sparse requests.
    refill_pct = 30;
    repeat (200) cycle();
    refill_pct = 0;
    for (int i = 0; i < 20 && bus.req_valid_i != '0; i++) cycle();

    // Flush whatever is left, then flush exactly 10 words while clients wait.
    flush = 1'b1;
    obs_done = 0;
    for (int i = 0; i < 300 && obs_done == 0; i++) cycle();
    chk("t5_pre_done", obs_done, 1);
    cycle();
    for (int i = 0; i < 10; i++) begin
      req(i % N, OP_PUSH, DW'(16'hA000 + i)); cycle();
    end
    cycle();
    chk("t5_usedw10", lusedw, 10);
    flush = 1'b1;
    obs_flush_rd = 0;
    obs_done = 0;
    cycle();
    for (int c = 0; c < N; c++) req(c, OP_PUSH, DW'($urandom));
    for (int i = 0; i < 40 && obs_done == 0; i++) cycle();
    chk("t5_usedw0", lusedw, 0);
    chk("t5_resume_grant", bus.req_ready_o, 4'b0100);
    repeat (3) cycle();
    chk("t5_rd_pulses", obs_flush_rd, 10);
    chk("t5_done_once", obs_done, 1);
    for (int i = 0; i < 20 && bus.req_valid_i != '0; i++) cycle();

    // Reset in the middle of FLUSH.
    for (int i = 0; i < 5; i++) begin
      req(0, OP_PUSH, DW'(i)); cycle();
    end
    cycle();
    flush = 1'b1;
    cycle();
    chk("t6_busy", busy, 1);
    #2 arstn = 1'b0;
    #1 chk_zero("t6_flush");
    model_reset();
    @(posedge clk);
    #1 arstn = 1'b1;

    // Reset with a pop response pending.
    req(0, OP_PUSH, 16'h5555); cycle();
    req(0, OP_POP, '0);        cycle();
    chk("t6_pend_data", bus.rsp_data_o, 16'h5555);
    #2 arstn = 1'b0;
    #1 chk_zero("t6_rsp");
    model_reset();
    for (int c = 0; c < N; c++) req(c, OP_PUSH, DW'($urandom));
    @(posedge clk);
    #1 arstn = 1'b1;
    #1 chk("t6_first", bus.req_ready_o, 4'b0001);
    grants.delete();
    repeat (5) cycle();
    chk("t6_n", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) chk("t6_order", grants[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
Shares one lifo instance (DWIDTH/AWIDTH, wrreq/rdreq/q/empty/full/usedw interface) between N_CLIENTS requesters.
- Each client issues push or pop commands over a valid/ready handshake.
- The arbiter grants one command per cycle, round-robin, and drives the lifo.
- Each completed command gets a per-client response with data and an error flag.
- A flush sequencer drains the lifo on request.

Parameters:
N_CLIENTS, 4, number of requesters (2..16)
DWIDTH, 16, data width; must match lifo DWIDTH
AWIDTH, 8, lifo address width; usedw is AWIDTH+1 bits

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
req_valid_i  in  N_CLIENTS  per-client command valid
req_op_i  in  N_CLIENTS  per-client op: 0 = push, 1 = pop
req_data_i  in  N_CLIENTS*DWIDTH  per-client push data (client i at slice i)
req_ready_o  out  N_CLIENTS  one-hot grant/accept
rsp_valid_o  out  N_CLIENTS  one-hot response strobe
rsp_err_o  out  1  response error: push to full or pop from empty
rsp_data_o  out  DWIDTH  pop data, valid with rsp_valid_o
flush_i  in  1  request to drain the lifo
flush_done_o  out  1  one-cycle pulse when drain completes
busy_o  out  1  high while state is FLUSH
lifo_wrreq_o  out  1  to lifo wrreq_i
lifo_rdreq_o  out  1  to lifo rdreq_i
lifo_data_o  out  DWIDTH  to lifo data_i
lifo_q_i  in  DWIDTH  from lifo q_o
lifo_empty_i  in  1  from lifo empty_o
lifo_full_i  in  1  from lifo full_o
lifo_usedw_i  in  AWIDTH+1  from lifo usedw_o

Behaviour:
Reset
- All outputs go to 0 asynchronously.
- State = RUN; round-robin pointer = N_CLIENTS-1, so client 0 has first priority.
- Any pending response is dropped.

Arbitration (state RUN)
- Combinational grant: the first requester with valid set, searching from pointer+1 upward and wrapping.
- req_ready_o[g]=1 in the same cycle; a handshake occurs when valid and ready are both 1.
- Pointer updates to g only on a handshake.
- Clients hold valid, op and data stable until ready; dropping valid without a handshake is illegal (assertion).

Lifo drive on a handshake in cycle T
- Push and lifo_full_i=0: lifo_wrreq_o=1, lifo_data_o=req_data_i[g].
- Pop and lifo_empty_i=0: lifo_rdreq_o=1.
- Push to full, or pop from empty: no lifo strobe; the command is still consumed.
- At most one of lifo_wrreq_o / lifo_rdreq_o is high in any cycle.
- The arbiter never issues wrreq and rdreq together.

Response
- In cycle T+1: rsp_valid_o[g]=1 for every handshake, push or pop.
- rsp_err_o=1 if the op was rejected at T.
- rsp_data_o = lifo_q_i for a successful pop (combinational pass-through; lifo read latency is 1); 0 otherwise.
- Back-to-back handshakes give back-to-back responses, so throughput is one op per cycle.

Flags
- lifo_full_i and lifo_empty_i are sampled in cycle T and reflect all ops up to T-1.
- This is exact because the arbiter issues at most one op per cycle.

FSM states RUN, FLUSH, DONE
- RUN -> FLUSH: flush_i=1. From the next cycle req_ready_o=0; a handshake in the transition cycle still completes.
- FLUSH: lifo_rdreq_o=1 while lifo_empty_i=0; popped data is discarded; busy_o=1; flush_i is ignored.
- FLUSH -> DONE: lifo_empty_i=1.
- DONE: flush_done_o=1 for one cycle, then -> RUN.
- Flush of an already-empty lifo: FLUSH lasts 1 cycle; flush_done_o is 2 cycles after flush_i.
- Round-robin pointer is unchanged across a flush.
- lifo_usedw_i is monitored only (assertion: never exceeds 2**AWIDTH).

Decomposition:
Package lifo_arb_pkg:
- state enum {RUN, FLUSH, DONE}
- localparams OP_PUSH=1'b0, OP_POP=1'b1

Sub-module rr_arbiter:
- Parameter N; inputs req[N], advance.
- Output grant one-hot; holds the priority pointer internally.

Test Plan:
- Client 0 pushes 0x1111, 0x2222; client 2 pops twice -> responses 0x2222 then 0x1111; err=0; rsp_valid_o[2] in cycle T+1 of each pop.
- All 4 clients hold valid continuously -> grant order 0,1,2,3,0,...; no client is granted twice before the others; lifo_wrreq_o is never high together with lifo_rdreq_o.
- Pop on an empty lifo -> rsp_err_o=1, rsp_data_o=0, no lifo_rdreq_o pulse, usedw stays 0.
- Push 2**AWIDTH words, then push 0xBEEF -> last response err=1, usedw=256; popping all returns data in reverse order with no 0xBEEF.
- Fill 10 words, pulse flush_i while clients request -> no req_ready_o during FLUSH, exactly 10 rdreq pulses, flush_done_o once, usedw=0, arbitration resumes.
- Assert arstn_i low during FLUSH and during a pending pop response -> all outputs 0 immediately; after release state=RUN and client 0 is granted first.
